// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between the instruction cache (port 0)
// and the data cache (port 1); one transaction at a time, each access bounded by a watchdog.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_p0_read,
   input  logic [3:0]  i_p0_write,
   input  logic [31:0] i_p0_addr,
   input  logic [31:0] i_p0_wdata,
   output logic        o_p0_grant,
   output logic        o_p0_ready,
   output logic [31:0] o_p0_rdata,
   input  logic        i_p1_read,
   input  logic [3:0]  i_p1_write,
   input  logic [31:0] i_p1_addr,
   input  logic [31:0] i_p1_wdata,
   output logic        o_p1_grant,
   output logic        o_p1_ready,
   output logic [31:0] o_p1_rdata,
   output logic        o_mem_read,
   output logic [3:0]  o_mem_write,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready,
   output logic        o_timeout_err
);

   localparam int unsigned      CntW   = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StGrant, StAccess, StDone} state_e;

   state_e              r_state, w_state_d;
   logic                r_sel, w_sel_d;
   logic                r_last, w_last_d;
   logic [1:0]          r_grant, w_grant_d;
   logic [1:0]          r_ready, w_ready_d;
   logic                r_mem_read, w_mem_read_d;
   logic [3:0]          r_mem_write, w_mem_write_d;
   logic [31:0]         r_mem_addr, w_mem_addr_d;
   logic [31:0]         r_mem_wdata, w_mem_wdata_d;
   logic [1:0][31:0]    r_rdata, w_rdata_d;
   logic [CntW-1:0]     r_cnt, w_cnt_d;
   logic                r_timeout_err, w_timeout_err_d;

   logic [1:0]          w_rd;
   logic [1:0][3:0]     w_be;
   logic [1:0][31:0]    w_addr;
   logic [1:0][31:0]    w_wdata;
   logic [1:0]          w_req;
   logic [CntW-1:0]     w_cnt_inc;

   assign w_rd      = {i_p1_read, i_p0_read};
   assign w_be      = {i_p1_write, i_p0_write};
   assign w_addr    = {i_p1_addr, i_p0_addr};
   assign w_wdata   = {i_p1_wdata, i_p0_wdata};
   assign w_req     = {i_p1_read | (|i_p1_write), i_p0_read | (|i_p0_write)};
   assign w_cnt_inc = r_cnt + CntW'(1);

   always_comb begin
      w_state_d       = r_state;
      w_sel_d         = r_sel;
      w_last_d        = r_last;
      w_grant_d       = r_grant;
      w_ready_d       = r_ready;
      w_mem_read_d    = r_mem_read;
      w_mem_write_d   = r_mem_write;
      w_mem_addr_d    = r_mem_addr;
      w_mem_wdata_d   = r_mem_wdata;
      w_rdata_d       = r_rdata;
      w_cnt_d         = r_cnt;
      w_timeout_err_d = r_timeout_err;

      unique case (r_state)
         StIdle: begin
            if (w_req != 2'b00) begin
               // On a tie the port that was not served last wins.
               w_sel_d   = (w_req == 2'b11) ? ~r_last : w_req[1];
               w_grant_d = w_sel_d ? 2'b10 : 2'b01;
               w_state_d = StGrant;
            end
         end
         StGrant: begin
            w_mem_addr_d  = w_addr[r_sel];
            w_mem_wdata_d = w_wdata[r_sel];
            if (w_be[r_sel] != 4'b0000) begin
               w_mem_write_d = w_be[r_sel];
               w_mem_read_d  = 1'b0;
            end else begin
               w_mem_write_d = 4'b0000;
               w_mem_read_d  = w_rd[r_sel];
            end
            if (!w_req[r_sel]) begin
               w_grant_d = 2'b00;
               w_state_d = StIdle;
            end else begin
               w_state_d = StAccess;
            end
         end
         StAccess: begin
            w_cnt_d = w_cnt_inc;
            if (i_mem_ready) begin
               w_mem_read_d     = 1'b0;
               w_mem_write_d    = 4'b0000;
               w_ready_d[r_sel] = 1'b1;
               if (r_mem_read) w_rdata_d[r_sel] = i_mem_rdata;
               w_state_d        = StDone;
            end else if (w_cnt_inc == CntMax) begin
               // Strobes have now been held for TIMEOUT cycles without a response.
               w_mem_read_d     = 1'b0;
               w_mem_write_d    = 4'b0000;
               w_ready_d[r_sel] = 1'b1;
               w_timeout_err_d  = 1'b1;
               if (r_mem_read) w_rdata_d[r_sel] = ERR_DATA;
               w_state_d        = StDone;
            end
         end
         StDone: begin
            if (!w_req[r_sel]) begin
               w_ready_d = 2'b00;
               w_grant_d = 2'b00;
               w_last_d  = r_sel;
               w_cnt_d   = '0;
               w_state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_sel         <= 1'b0;
         r_last        <= 1'b1;
         r_grant       <= 2'b00;
         r_ready       <= 2'b00;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 4'b0000;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_rdata       <= '0;
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_sel         <= w_sel_d;
         r_last        <= w_last_d;
         r_grant       <= w_grant_d;
         r_ready       <= w_ready_d;
         r_mem_read    <= w_mem_read_d;
         r_mem_write   <= w_mem_write_d;
         r_mem_addr    <= w_mem_addr_d;
         r_mem_wdata   <= w_mem_wdata_d;
         r_rdata       <= w_rdata_d;
         r_cnt         <= w_cnt_d;
         r_timeout_err <= w_timeout_err_d;
      end
   end

   assign o_p0_grant    = r_grant[0];
   assign o_p1_grant    = r_grant[1];
   assign o_p0_ready    = r_ready[0];
   assign o_p1_ready    = r_ready[1];
   assign o_p0_rdata    = r_rdata[0];
   assign o_p1_rdata    = r_rdata[1];
   assign o_mem_read    = r_mem_read;
   assign o_mem_write   = r_mem_write;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_wdata   = r_mem_wdata;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a memory responder plus a scoreboard of expected
// transactions, checked at each memory strobe and at each port ready.
module tb_mem_bus_arbiter;

   localparam logic [31:0] MemBase = 32'h1234_5638;
   localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

   typedef struct {
      int          port;
      bit          is_wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_read = 1'b0, p1_read = 1'b0;
   logic [3:0]  p0_write = '0, p1_write = '0;
   logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
   logic        p0_grant, p1_grant, p0_ready, p1_ready;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_read;
   logic [3:0]  mem_write;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        timeout_err;

   wire  [1:0]  rdy = {p1_ready, p0_ready};
   wire  [1:0]  gnt = {p1_grant, p0_grant};

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   int   mem_lat = 0;
   bit   mem_en = 1'b1;
   int   mem_cnt = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT(8), .ERR_DATA(ErrData)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_p0_read    (p0_read),
      .i_p0_write   (p0_write),
      .i_p0_addr    (p0_addr),
      .i_p0_wdata   (p0_wdata),
      .o_p0_grant   (p0_grant),
      .o_p0_ready   (p0_ready),
      .o_p0_rdata   (p0_rdata),
      .i_p1_read    (p1_read),
      .i_p1_write   (p1_write),
      .i_p1_addr    (p1_addr),
      .i_p1_wdata   (p1_wdata),
      .o_p1_grant   (p1_grant),
      .o_p1_ready   (p1_ready),
      .o_p1_rdata   (p1_rdata),
      .o_mem_read   (mem_read),
      .o_mem_write  (mem_write),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata),
      .i_mem_ready  (mem_ready),
      .o_timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] rdata_of(input int p);
      return (p == 1) ? p1_rdata : p0_rdata;
   endfunction

   // Memory responder: raises ready mem_lat cycles after a strobe rises, data = MemBase ^ addr.
   always @(negedge clk) begin
      mem_rdata = MemBase ^ mem_addr;
      if (mem_read || (mem_write != 4'd0)) begin
         mem_ready = mem_en && (mem_cnt == mem_lat);
         mem_cnt++;
      end else begin
         mem_ready = 1'b0;
         mem_cnt   = 0;
      end
   end

   // Scoreboard monitor: peek at each strobe, pop at each ready.
   logic       strobe_q = 1'b0;
   logic [1:0] rdy_q = 2'b00;
   always @(negedge clk) begin
      logic strobe;
      exp_t e;
      strobe = mem_read || (mem_write != 4'd0);
      if (rst_n && strobe && !strobe_q) begin
         if (sb.size() == 0) begin
            chk("unexpected_mem_access", 32'(strobe), 32'd0);
         end else begin
            chk("mem_addr", mem_addr, sb[0].addr);
            chk("mem_write", 32'(mem_write), 32'(sb[0].be));
            chk("mem_read", 32'(mem_read), 32'(!sb[0].is_wr));
            if (sb[0].is_wr) chk("mem_wdata", mem_wdata, sb[0].wdata);
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (rst_n && rdy[p] && !rdy_q[p]) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'(rdy[p]), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ready_port", 32'(p), 32'(e.port));
               if (!e.is_wr) chk("port_rdata", rdata_of(p), e.rdata);
            end
         end
      end
      strobe_q = strobe;
      rdy_q    = rdy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int port, input bit wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
      exp_t e;
      e.port  = port;
      e.is_wr = wr;
      e.addr  = addr;
      e.be    = wr ? be : 4'd0;
      e.wdata = wd;
      e.rdata = mem_en ? (MemBase ^ addr) : ErrData;
      sb.push_back(e);
   endtask

   task automatic req_read(input int port, input logic [31:0] addr);
      if (port == 0) begin
         p0_read = 1'b1; p0_addr = addr;
      end else begin
         p1_read = 1'b1; p1_addr = addr;
      end
      push(port, 1'b0, addr, 4'd0, 32'd0);
   endtask

   task automatic drop(input int port);
      if (port == 0) begin
         p0_read = 1'b0; p0_write = 4'd0;
      end else begin
         p1_read = 1'b0; p1_write = 4'd0;
      end
   endtask

   task automatic wait_ready(input int port, input string tag);
      int n;
      n = 0;
      while (rdy[port] !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk(tag, 32'(rdy[port]), 32'd1);
   endtask

   initial begin
      int n;
      int n_rd;
      int p;
      tick();
      tick();
      chk("rst_grant", 32'(gnt), 32'd0);
      chk("rst_ready", 32'(rdy), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single read on port 0, memory answers two cycles after the strobe.
      mem_lat = 2;
      req_read(0, 32'h0000_0040);
      tick();
      chk("t1_grant_at_t1", 32'(p0_grant), 32'd1);
      chk("t1_no_strobe_at_t1", 32'(mem_read), 32'd0);
      tick();
      chk("t1_strobe_at_t2", 32'(mem_read), 32'd1);
      tick();
      tick();
      chk("t1_not_ready_at_t4", 32'(p0_ready), 32'd0);
      tick();
      chk("t1_ready_at_t5", 32'(p0_ready), 32'd1);
      chk("t1_rdata", p0_rdata, 32'h1234_5678);
      chk("t1_p1_quiet", {p1_rdata[29:0], p1_grant, p1_ready}, 32'd0);
      drop(0);
      tick();
      chk("t1_release", 32'({gnt, rdy}), 32'd0);

      // Fresh reset, then simultaneous requests; port 1 write also asserts read.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      mem_lat = 1;
      req_read(0, 32'h0000_0100);
      p1_read  = 1'b1;
      p1_write = 4'b0011;
      p1_addr  = 32'h0000_0200;
      p1_wdata = 32'hAAAA_5555;
      push(1, 1'b1, 32'h0000_0200, 4'b0011, 32'hAAAA_5555);
      wait_ready(0, "t2_p0_first");
      chk("t2_p1_waiting", 32'({p1_grant, p1_ready}), 32'd0);
      drop(0);
      wait_ready(1, "t2_p1_write_done");
      chk("t2_p0_no_grant", 32'(p0_grant), 32'd0);
      chk("t2_write_keeps_rdata", p1_rdata, 32'd0);
      drop(1);
      tick();

      // Port 1 was served last: a tie goes to port 0, then service alternates.
      mem_lat = 0;
      req_read(0, 32'h0000_0300);
      req_read(1, 32'h0000_0400);
      tick();
      chk("t3_tie_p0", 32'(gnt), 32'd1);
      for (int i = 0; i < 4; i++) begin
         p = i % 2;
         wait_ready(p, "t3_alternate");
         chk("t3_other_no_grant", 32'(gnt[1 - p]), 32'd0);
         drop(p);
         tick();
         if (i < 3) req_read(p, 32'h0000_0300 + 32'(p * 256) + 32'((i + 1) * 16));
      end
      wait_ready(0, "t3_last_p0");
      drop(0);
      tick();

      // Watchdog: no response on a port 1 read.
      mem_en = 1'b0;
      chk("t4_err_clear_before", 32'(timeout_err), 32'd0);
      req_read(1, 32'h0000_0500);
      tick();
      n = 0;
      n_rd = 0;
      while (!p1_ready && n < 40) begin
         if (mem_read) n_rd++;
         tick();
         n++;
      end
      chk("t4_ready", 32'(p1_ready), 32'd1);
      chk("t4_strobe_cycles", 32'(n_rd), 32'd8);
      chk("t4_strobe_dropped", 32'(mem_read), 32'd0);
      chk("t4_err_data", p1_rdata, ErrData);
      chk("t4_timeout_err", 32'(timeout_err), 32'd1);
      drop(1);
      mem_en = 1'b1;
      tick();
      tick();
      chk("t4_err_sticky", 32'(timeout_err), 32'd1);

      // Request withdrawn while in GRANT: no access, pointer untouched.
      p0_read = 1'b1;
      p0_addr = 32'h0000_0600;
      tick();
      chk("t5_grant", 32'(p0_grant), 32'd1);
      p0_read = 1'b0;
      tick();
      chk("t5_grant_cleared", 32'(p0_grant), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_strobe", 32'(mem_read), 32'd0);
         chk("t5_no_ready", 32'(p0_ready), 32'd0);
         tick();
      end
      req_read(0, 32'h0000_0700);
      req_read(1, 32'h0000_0800);
      tick();
      chk("t5_pointer_kept", 32'(gnt), 32'd1);
      wait_ready(0, "t5_p0_done");
      drop(0);
      wait_ready(1, "t5_p1_done");
      drop(1);
      tick();
      chk("t5_err_still_sticky", 32'(timeout_err), 32'd1);

      // Asynchronous reset in the middle of ACCESS.
      mem_lat = 6;
      req_read(0, 32'h0000_0900);
      tick();
      tick();
      chk("t6_in_access", 32'(mem_read), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_strobe_async", 32'(mem_read), 32'd0);
      chk("t6_grant_async", 32'(gnt), 32'd0);
      chk("t6_err_async", 32'(timeout_err), 32'd0);
      drop(0);
      sb.delete();
      tick();
      chk("t6_no_ready_in_reset", 32'(rdy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      mem_lat = 0;
      req_read(0, 32'h0000_0A00);
      wait_ready(0, "t6_after_reset");
      chk("t6_rdata", p0_rdata, MemBase ^ 32'h0000_0A00);
      drop(0);
      tick();
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
